// File: rtl/an_code_pkg.sv
// AN-code constants, encoder state encoding and error-location helpers shared
// by the encoder, the decoder and the LUT generators.
package an_code_pkg;
  localparam int A      = 6311;
  localparam int A_BITS = 13;
  localparam int N_BITS = 21;
  localparam int W_BITS = 34;
  localparam int L_BITS = 6;

  typedef enum logic [1:0] {IDLE, MUL, INJ, OUT} state_e;

  // Magnitude of a signed location; -2^L_BITS maps to 2^L_BITS, which is out of range anyway
  function automatic logic [L_BITS:0] loc_mag(input logic [L_BITS:0] l);
    return l[L_BITS] ? (~l + 1'b1) : l;
  endfunction

  function automatic logic loc_valid(input logic [L_BITS:0] l);
    logic [L_BITS:0] m;
    m = loc_mag(l);
    return (m != '0) && (m <= (L_BITS+1)'(W_BITS-1));
  endfunction
endpackage

// File: rtl/an_err_term.sv
// Signed power-of-two error term for one location: +l -> +2^(l-1), -l -> -2^(l-1),
// zero or out-of-range location -> 0. Output is W_BITS two's complement.
import an_code_pkg::*;

module an_err_term (
  input  logic [L_BITS:0]   l,
  output logic [W_BITS-1:0] term
);
  logic [W_BITS-1:0] pow;

  always_comb begin
    pow  = '0;
    term = '0;
    if (loc_valid(l)) begin
      pow  = W_BITS'(1) << (loc_mag(l) - 1'b1);
      term = l[L_BITS] ? (~pow + 1'b1) : pow;
    end
  end
endmodule

// File: rtl/an_encoder_20bits.sv
// Serial shift-add AN encoder (W = A*N) with up to two injected signed
// power-of-two arithmetic errors; one operand in flight at a time.
import an_code_pkg::*;

module an_encoder_20bits (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] n_in,
  input  logic [L_BITS:0]   err_l1,
  input  logic [L_BITS:0]   err_l2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] w_out,
  output logic [N_BITS-1:0] n_out,
  output logic              w_clean
);
  localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);
  localparam logic [3:0]        LAST  = 4'(A_BITS-1);

  state_e              state;
  logic [W_BITS-1:0]   acc;
  logic [3:0]          cnt;
  logic [N_BITS-1:0]   n_q;
  logic [L_BITS:0]     l1_q, l2_q;
  logic [W_BITS-1:0]   t1, t2, addend;

  an_err_term u_term1 (.l(l1_q), .term(t1));
  an_err_term u_term2 (.l(l2_q), .term(t2));

  assign addend = A_VEC[cnt] ? (W_BITS'(n_q) << cnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      w_out     <= '0;
      n_out     <= '0;
      w_clean   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      n_q       <= '0;
      l1_q      <= '0;
      l2_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready comes back one cycle after the output handshake
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            n_q      <= n_in;
            l1_q     <= err_l1;
            l2_q     <= err_l2;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          acc <= acc + addend;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) state <= INJ;
        end
        INJ: begin
          w_out     <= acc + t1 + t2;
          w_clean   <= (t1 == '0) && (t2 == '0);
          n_out     <= n_q;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_an_encoder_20bits.sv
// Self-checking bench for an_encoder_20bits: directed test-plan vectors,
// backpressure, mid-operation reset and randomized operands vs. an integer model.
module tb_an_encoder_20bits;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, w_clean;
  logic [20:0] n_in, n_out;
  logic [6:0]  err_l1, err_l2;
  logic [33:0] w_out;
  int errors = 0;
  int checks = 0;

  an_encoder_20bits dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .err_l1(err_l1), .err_l2(err_l2), .out_valid(out_valid),
    .out_ready(out_ready), .w_out(w_out), .n_out(n_out), .w_clean(w_clean)
  );

  always #5 clk = ~clk;

  function automatic longint term(input logic [6:0] l);
    int k;
    k = $signed(l);
    if (k == 0 || k > 33 || k < -33) return 0;
    return (k > 0) ? (longint'(1) <<< (k - 1)) : -(longint'(1) <<< (-k - 1));
  endfunction

  function automatic logic [33:0] model_w(input logic [20:0] n, input logic [6:0] l1, input logic [6:0] l2);
    longint s;
    s = longint'(6311) * longint'(n) + term(l1) + term(l2);
    return 34'(s & ((longint'(1) <<< 34) - 1));
  endfunction

  function automatic logic model_clean(input logic [6:0] l1, input logic [6:0] l2);
    return term(l1) == 0 && term(l2) == 0;
  endfunction

  // Drives one operand; returns at the negedge following the accept edge (edge 0)
  task automatic send(input logic [20:0] n, input logic [6:0] l1, input logic [6:0] l2);
    int guard = 0;
    while (!in_ready && guard < 40) begin @(negedge clk); guard++; end
    n_in = n; err_l1 = l1; err_l2 = l2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_in = 21'($urandom); err_l1 = 7'($urandom); err_l2 = 7'($urandom);
  endtask

  // Counts negedges from the accept negedge until out_valid; bounded
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 0; out_ready = 0; n_in = 0; err_l1 = 0; err_l2 = 0;
    #12;
    checks++;
    if ({in_ready, out_valid, w_clean} !== 3'b100 || w_out !== 34'd0 || n_out !== 21'd0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b w_clean=%b w_out=%0d n_out=%0d, want 1 0 0 0 0",
               in_ready, out_valid, w_clean, w_out, n_out);
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_directed;
    logic [20:0] nv [6] = '{21'd1, 21'd2, 21'h1FFFFF, 21'd0, 21'd1, 21'd1};
    logic [6:0]  l1v[6] = '{7'd0, 7'd5, 7'd0, -7'sd1, -7'sd3, 7'd3};
    logic [6:0]  l2v[6] = '{7'd0, -7'sd14, 7'd0, 7'd0, 7'd40, -7'sd3};
    logic [33:0] wv [6] = '{34'd6311, 34'd4446, 34'd13235119961, 34'd17179869183, 34'd6307, 34'd6311};
    logic        cv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      send(nv[i], l1v[i], l2v[i]);
      wait_out(cyc);
      checks++;
      if (cyc != 14) begin
        errors++; $display("FAIL latency[%0d]: got %0d cycles, want 14", i, cyc);
      end
      checks++;
      if (w_out !== wv[i] || w_clean !== cv[i] || n_out !== nv[i]) begin
        errors++;
        $display("FAIL directed[%0d]: w_out=%0d w_clean=%b n_out=%0d, want %0d %b %0d",
                 i, w_out, w_clean, n_out, wv[i], cv[i], nv[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL post_hs[%0d]: out_valid=%b in_ready=%b, want 0 0", i, out_valid, in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL ready_return[%0d]: in_ready=%b, want 1", i, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [33:0] exp_w;
    exp_w = model_w(21'd12345, 7'd20, -7'sd7);
    send(21'd12345, 7'd20, -7'sd7);
    wait_out(cyc);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || w_out !== exp_w || n_out !== 21'd12345 || w_clean !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b w_out=%0d n_out=%0d, want 1 0 %0d 12345",
                 k, out_valid, in_ready, w_out, n_out, exp_w);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hs: out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    send(21'd999, 7'd2, 7'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    send(21'd3, 7'd0, 7'd0);
    wait_out(cyc);
    checks++;
    if (cyc != 14 || w_out !== 34'd18933 || w_clean !== 1'b1 || n_out !== 21'd3) begin
      errors++;
      $display("FAIL after_reset: cyc=%0d w_out=%0d w_clean=%b n_out=%0d, want 14 18933 1 3",
               cyc, w_out, w_clean, n_out);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0; @(negedge clk);
  endtask

  task automatic test_random;
    int cyc;
    logic [20:0] n;
    logic [6:0]  l1, l2;
    for (int i = 0; i < 40; i++) begin
      n  = 21'($urandom);
      l1 = 7'($urandom_range(0, 127));
      l2 = ($urandom_range(0, 3) == 0) ? l1 : 7'($urandom_range(0, 127));
      send(n, l1, l2);
      wait_out(cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (cyc != 14 || w_out !== model_w(n, l1, l2) || w_clean !== model_clean(l1, l2) || n_out !== n) begin
        errors++;
        $display("FAIL random[%0d]: cyc=%0d w_out=%0d w_clean=%b n_out=%0d, want 14 %0d %b %0d (l1=%0d l2=%0d)",
                 i, cyc, w_out, w_clean, n_out, model_w(n, l1, l2), model_clean(l1, l2), n,
                 $signed(l1), $signed(l2));
      end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
